// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: register scoreboard, memory-op limit and control serialization.
// Define ISU_WB_BYPASS_EN to let a same-cycle writeback clear hazards before the issue check.
module issue_scheduler #(
    parameter int unsigned MEM_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IFQ_empty,
    output logic        IFQ_rden,
    input  logic [4:0]  DU_rs1,
    input  logic [4:0]  DU_rs2,
    input  logic [4:0]  DU_rd,
    input  logic        DU_rs1_valid,
    input  logic        DU_rs2_valid,
    input  logic        DU_regwrite,
    input  logic        DU_j,
    input  logic        DU_br,
    input  logic        DU_memread,
    input  logic        DU_memwrite,
    input  logic        EX_ready,
    output logic        ISU_issue,
    input  logic        WB_valid,
    input  logic [4:0]  WB_rd,
    input  logic        MEM_done,
    input  logic        BR_resolve,
    input  logic        BR_flush,
    output logic [31:0] ISU_busy,
    output logic        ISU_state
);

    typedef enum logic {StRun = 1'b0, StWaitCtrl = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] wb_clr;
    logic [31:0] haz_busy;
    logic        raw, waw, memblk, is_mem, issue;
    logic        cnt_inc, cnt_dec;

    assign wb_clr = (WB_valid && WB_rd != 5'd0) ? (32'd1 << WB_rd) : 32'd0;

`ifdef ISU_WB_BYPASS_EN
    assign haz_busy = busy_q & ~wb_clr;
`else
    assign haz_busy = busy_q;
`endif

    assign raw = (DU_rs1_valid && DU_rs1 != 5'd0 && haz_busy[DU_rs1]) ||
                 (DU_rs2_valid && DU_rs2 != 5'd0 && haz_busy[DU_rs2]);
    assign waw    = DU_regwrite && haz_busy[DU_rd];
    assign is_mem = DU_memread || DU_memwrite;
    assign memblk = is_mem && (cnt_q == 3'(MEM_MAX));

    assign issue = !rst && (state_q == StRun) && !IFQ_empty && EX_ready &&
                   !raw && !waw && !memblk && !BR_flush;

    assign ISU_issue = issue;
    assign IFQ_rden  = issue;
    assign ISU_busy  = busy_q;
    assign ISU_state = (state_q == StWaitCtrl);

    always_comb begin
        // Clear first so a same-index set in this cycle wins.
        busy_d = busy_q & ~wb_clr;
        if (issue && DU_regwrite && DU_rd != 5'd0) begin
            busy_d[DU_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign cnt_inc = issue && is_mem;
    assign cnt_dec = MEM_done && (cnt_q != 3'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 3'd1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (issue && (DU_j || DU_br)) begin
                    state_d = StWaitCtrl;
                end
            end
            StWaitCtrl: begin
                if (BR_resolve || BR_flush) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            busy_q  <= 32'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler (MEM_MAX = 2).
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        IFQ_empty;
    logic        IFQ_rden;
    logic [4:0]  DU_rs1, DU_rs2, DU_rd;
    logic        DU_rs1_valid, DU_rs2_valid, DU_regwrite;
    logic        DU_j, DU_br, DU_memread, DU_memwrite;
    logic        EX_ready;
    logic        ISU_issue;
    logic        WB_valid;
    logic [4:0]  WB_rd;
    logic        MEM_done, BR_resolve, BR_flush;
    logic [31:0] ISU_busy;
    logic        ISU_state;

    int checks = 0;
    int errors = 0;

    issue_scheduler #(.MEM_MAX(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .IFQ_empty   (IFQ_empty),
        .IFQ_rden    (IFQ_rden),
        .DU_rs1      (DU_rs1),
        .DU_rs2      (DU_rs2),
        .DU_rd       (DU_rd),
        .DU_rs1_valid(DU_rs1_valid),
        .DU_rs2_valid(DU_rs2_valid),
        .DU_regwrite (DU_regwrite),
        .DU_j        (DU_j),
        .DU_br       (DU_br),
        .DU_memread  (DU_memread),
        .DU_memwrite (DU_memwrite),
        .EX_ready    (EX_ready),
        .ISU_issue   (ISU_issue),
        .WB_valid    (WB_valid),
        .WB_rd       (WB_rd),
        .MEM_done    (MEM_done),
        .BR_resolve  (BR_resolve),
        .BR_flush    (BR_flush),
        .ISU_busy    (ISU_busy),
        .ISU_state   (ISU_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; single-cycle side strobes drop afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        WB_valid   = 1'b0;
        WB_rd      = 5'd0;
        MEM_done   = 1'b0;
        BR_resolve = 1'b0;
        BR_flush   = 1'b0;
    endtask

    task automatic head(input logic [4:0] rs1, input logic v1, input logic [4:0] rs2,
                        input logic v2, input logic [4:0] rd, input logic rw,
                        input logic j, input logic br, input logic mr, input logic mw);
        IFQ_empty    = 1'b0;
        DU_rs1       = rs1;
        DU_rs1_valid = v1;
        DU_rs2       = rs2;
        DU_rs2_valid = v2;
        DU_rd        = rd;
        DU_regwrite  = rw;
        DU_j         = j;
        DU_br        = br;
        DU_memread   = mr;
        DU_memwrite  = mw;
        #1;
    endtask

    task automatic idle();
        head(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        IFQ_empty = 1'b1;
        #1;
    endtask

    task automatic addi(input logic [4:0] rd);
        head(5'd0, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load();
        head(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic beq();
        head(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        EX_ready = 1'b1;
        WB_valid = 1'b0; WB_rd = 5'd0; MEM_done = 1'b0;
        BR_resolve = 1'b0; BR_flush = 1'b0;
        addi(5'd1);
        check_eq("rst_issue", {31'd0, ISU_issue}, 32'd0);
        check_eq("rst_rden", {31'd0, IFQ_rden}, 32'd0);
        tick();
        check_eq("rst_busy", ISU_busy, 32'd0);
        check_eq("rst_state", {31'd0, ISU_state}, 32'd0);
        rst = 1'b0;

        // Back-to-back independent issue.
        addi(5'd1);
        check_eq("addi_x1_issue", {31'd0, ISU_issue}, 32'd1);
        check_eq("addi_x1_rden", {31'd0, IFQ_rden}, 32'd1);
        tick();
        check_eq("busy_after_x1", ISU_busy, 32'h2);
        addi(5'd2);
        check_eq("addi_x2_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("busy_after_x2", ISU_busy, 32'h6);
        idle();
        WB_valid = 1'b1; WB_rd = 5'd2;
        tick();
        check_eq("wb_x2_busy", ISU_busy, 32'h2);

        // add x3,x1,x2 while x1 writes back.
        WB_valid = 1'b1; WB_rd = 5'd1;
        head(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ISU_WB_BYPASS_EN
        check_eq("raw_wb_same_cycle", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("raw_wb_busy", ISU_busy, 32'h8);
`else
        check_eq("raw_wb_same_cycle", {31'd0, ISU_issue}, 32'd0);
        tick();
        check_eq("raw_wb_busy", ISU_busy, 32'h0);
        head(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("raw_next_cycle", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("add_x3_busy", ISU_busy, 32'h8);
`endif

        // WAW and RAW on x3 stall; set-wins on x4.
        addi(5'd3);
        check_eq("waw_stall", {31'd0, ISU_issue}, 32'd0);
        head(5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("raw_rs2_stall", {31'd0, ISU_issue}, 32'd0);
        WB_valid = 1'b1; WB_rd = 5'd4;
        addi(5'd4);
        check_eq("set_wins_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("set_wins_busy", ISU_busy, 32'h18);
        idle();
        WB_valid = 1'b1; WB_rd = 5'd3;
        tick();
        WB_valid = 1'b1; WB_rd = 5'd4;
        #1;
        tick();
        check_eq("busy_drained", ISU_busy, 32'h0);

        // Memory limit.
        load();
        check_eq("ld1_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        load();
        check_eq("ld2_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        load();
        check_eq("ld3_stall", {31'd0, ISU_issue}, 32'd0);
        tick();
        MEM_done = 1'b1;
        load();
        check_eq("ld3_stall_done", {31'd0, ISU_issue}, 32'd0);
        tick();
        load();
        check_eq("ld3_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        head(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("st_stall", {31'd0, ISU_issue}, 32'd0);

        // Flush in RUN: no issue, no state change.
        BR_flush = 1'b1;
        addi(5'd5);
        check_eq("flush_issue", {31'd0, ISU_issue}, 32'd0);
        tick();
        check_eq("flush_busy", ISU_busy, 32'h0);
        check_eq("flush_state", {31'd0, ISU_state}, 32'd0);
        addi(5'd5);
        check_eq("post_flush_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("busy_x5", ISU_busy, 32'h20);
        load();
        check_eq("flush_cnt_kept", {31'd0, ISU_issue}, 32'd0);

        // Drain, then one extra MEM_done at cnt 0 must not underflow.
        idle();
        MEM_done = 1'b1; WB_valid = 1'b1; WB_rd = 5'd5;
        tick();
        MEM_done = 1'b1;
        tick();
        MEM_done = 1'b1;
        tick();
        load();
        tick();
        load();
        check_eq("no_underflow_ld2", {31'd0, ISU_issue}, 32'd1);
        tick();
        load();
        check_eq("no_underflow_ld3", {31'd0, ISU_issue}, 32'd0);
        idle();
        MEM_done = 1'b1;
        tick();
        MEM_done = 1'b1;
        tick();

        // Branch serialization.
        beq();
        check_eq("beq_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("beq_state", {31'd0, ISU_state}, 32'd1);
        addi(5'd1);
        check_eq("br_wait1", {31'd0, ISU_issue}, 32'd0);
        tick();
        addi(5'd1);
        check_eq("br_wait2", {31'd0, ISU_issue}, 32'd0);
        tick();
        BR_resolve = 1'b1;
        addi(5'd1);
        check_eq("br_wait3", {31'd0, ISU_issue}, 32'd0);
        tick();
        check_eq("br_resolved_state", {31'd0, ISU_state}, 32'd0);
        addi(5'd1);
        check_eq("br_next_issue", {31'd0, ISU_issue}, 32'd1);
        tick();

        // jal x2, then leave WAIT_CTRL via flush.
        head(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("jal_issue", {31'd0, ISU_issue}, 32'd1);
        tick();
        check_eq("jal_state", {31'd0, ISU_state}, 32'd1);
        check_eq("jal_busy", ISU_busy, 32'h6);
        BR_flush = 1'b1;
        load();
        check_eq("wait_flush_issue", {31'd0, ISU_issue}, 32'd0);
        tick();
        check_eq("wait_flush_state", {31'd0, ISU_state}, 32'd0);
        check_eq("wait_flush_busy", ISU_busy, 32'h6);
        load();
        tick();
        beq();
        tick();
        check_eq("pre_rst_state", {31'd0, ISU_state}, 32'd1);

        // Reset mid-operation: busy=0x6, cnt=1, WAIT_CTRL.
        rst = 1'b1;
        addi(5'd7);
        check_eq("mid_rst_issue", {31'd0, ISU_issue}, 32'd0);
        tick();
        check_eq("mid_rst_busy", ISU_busy, 32'h0);
        check_eq("mid_rst_state", {31'd0, ISU_state}, 32'd0);
        addi(5'd7);
        check_eq("mid_rst_hold", {31'd0, IFQ_rden}, 32'd0);
        tick();
        rst = 1'b0;
        load();
        check_eq("post_rst_ld1", {31'd0, ISU_issue}, 32'd1);
        tick();
        load();
        check_eq("post_rst_ld2", {31'd0, ISU_issue}, 32'd1);
        tick();
        load();
        check_eq("post_rst_ld3", {31'd0, ISU_issue}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

In-order single-issue scheduler between the instruction fetch queue and the execute backend. It takes the decoded fields of the IFQ head instruction and decides each cycle whether that instruction may be dispatched. Issue is blocked on:
- register hazards, tracked in a 32-entry busy-bit scoreboard;
- the outstanding-memory-operation limit;
- an unresolved control transfer.

On issue it pops the IFQ and pulses the dispatch strobe to the backend.

## Interface
Parameters:
- MEM_MAX, default 2: maximum outstanding memory ops (loads + stores), range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IFQ_empty  in  1  IFQ holds no instruction; decoded inputs are don't-care while high.
- IFQ_rden  out  1  pop IFQ head; equals ISU_issue.
- DU_rs1, DU_rs2, DU_rd  in  5 each  register indices of the head instruction.
- DU_rs1_valid, DU_rs2_valid  in  1 each  source operand is actually read.
- DU_regwrite  in  1  head writes DU_rd; never asserted with rd = 0.
- DU_j, DU_br  in  1 each  head is a jump (JAL/JALR) or a conditional branch.
- DU_memread, DU_memwrite  in  1 each  head is a load or a store.
- EX_ready  in  1  backend can accept an instruction this cycle.
- ISU_issue  out  1  head dispatched this cycle (combinational).
- WB_valid, WB_rd  in  1, 5  register writeback completes this cycle.
- MEM_done  in  1  one memory op retired this cycle.
- BR_resolve  in  1  the in-flight jump or branch has resolved.
- BR_flush  in  1  redirect; the IFQ is being flushed externally this cycle.
- ISU_busy  out  32  scoreboard vector; bit 0 is always 0.
- ISU_state  out  1  0 = RUN, 1 = WAIT_CTRL.

## Operation
Hazard terms:
- raw = (DU_rs1_valid && rs1≠0 && busy[rs1]) || (DU_rs2_valid && rs2≠0 && busy[rs2]).
- waw = DU_regwrite && busy[rd].
- memblk = (DU_memread || DU_memwrite) && cnt == MEM_MAX.

Issue rule: ISU_issue = state==RUN && !IFQ_empty && EX_ready && !raw && !waw && !memblk && !BR_flush.

Scoreboard, updated at the edge:
- Set busy[DU_rd] on issue when DU_regwrite.
- Clear busy[WB_rd] when WB_valid and WB_rd≠0.
- Same index set and cleared in one cycle: set wins.
- WB_rd = 0 is ignored.

Memory counter (cnt, width 3):
- +1 on issue of a memory op; −1 on MEM_done.
- Both in the same cycle: cnt unchanged.
- MEM_done with cnt = 0: ignored, no underflow.

State machine:
- RUN → WAIT_CTRL on issue of an instruction with DU_j || DU_br.
- WAIT_CTRL → RUN on BR_resolve or BR_flush.
- BR_flush in RUN: no issue that cycle; state stays RUN.
- Control transfers are serialized, so nothing younger than the branch is in flight. A flush therefore leaves the busy bits and cnt untouched.

Reset: state = RUN, busy = 0, cnt = 0. ISU_issue and IFQ_rden are held 0 while rst is high.

## Timing
- Issue decision is combinational from the inputs and registered state. Pop and dispatch happen in the same cycle.
- Issue in cycle t makes busy[rd] visible from t+1. A dependent instruction at the head in t+1 stalls.
- Writeback in cycle t: a dependent instruction issues in t+1, or in t when ISU_WB_BYPASS_EN is defined.
- Branch issued in t with BR_resolve in t+k: the next issue is no earlier than t+k+1.
- Back-to-back independent instructions issue every cycle.

## Configuration
- ISU_WB_BYPASS_EN defined: the raw and waw terms use busy & ~onehot(WB_rd) when WB_valid. A writeback in the same cycle unblocks issue; the set-wins rule still holds when the new instruction writes the same rd.
- Not defined: hazard checks use the registered busy only, giving a one-cycle writeback-to-issue penalty.

## Test plan
- Reset, then `addi x1` issued with EX_ready=1 → ISU_issue=1 in t; ISU_busy=0x2 in t+1; ISU_issue=1 again in t+1 for independent `addi x2`.
- `add x3,x1,x2` at head with busy[1]=1, WB_valid=1/WB_rd=1 in cycle t:
  - bypass defined → issue in t;
  - not defined → issue in t+1;
  - in both cases busy[1]=0 afterwards.
- MEM_MAX=2, three consecutive loads, no MEM_done → first two issue, third stalls. MEM_done in cycle t → third issues in t+1 (cnt 2→1→2).
- `beq` issued at t → ISU_state=1 from t+1; no issue in t+1..t+3; BR_resolve at t+3 → issue at t+4.
- BR_flush asserted in RUN with a ready head → ISU_issue=0; busy and cnt unchanged.
- rst asserted mid-operation with busy=0x6, cnt=1, state WAIT_CTRL → next cycle busy=0, cnt=0, state=RUN, no issue while rst is high.
